// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte sources. One byte
// is accepted at a time over a valid/ready handshake. The accepted byte is
// registered onto o_tx_data, and a one-cycle o_tx_start pulse is issued. The
// arbiter then tracks i_tx_busy through the whole frame before it will accept
// the next byte.
//
// Optional feature (compile-time macro UART_TX_ARB_LOCK_EN):
//   When defined, a byte accepted with i_last low locks the arbiter to that
//   requester until a byte with i_last high is accepted from it.
//   When undefined, i_last is ignored and every byte is arbitrated on its own.
//
// Ports:
//   i_clk       clock
//   i_reset     asynchronous, active-high reset
//   i_valid     [NUM_REQ]            per-requester byte valid
//   i_data      [NUM_REQ*DATA_BITS]  flattened bytes, requester k at [k*DATA_BITS +: DATA_BITS]
//   i_last      [NUM_REQ]            last byte of packet (lock feature only)
//   o_ready     [NUM_REQ]            one-hot accept strobe (combinational)
//   o_grant     [NUM_REQ]            one-hot owner of the frame in flight, 0 when idle
//   o_tx_data   [DATA_BITS]          registered byte to uart_tx.i_data
//   o_tx_start  1                    registered one-cycle start to uart_tx.i_start
//   i_tx_busy   1                    uart_tx.o_busy
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BITS = 8
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic [NUM_REQ-1:0]             i_valid,
   input  logic [NUM_REQ*DATA_BITS-1:0]   i_data,
   input  logic [NUM_REQ-1:0]             i_last,
   output logic [NUM_REQ-1:0]             o_ready,
   output logic [NUM_REQ-1:0]             o_grant,
   output logic [DATA_BITS-1:0]           o_tx_data,
   output logic                           o_tx_start,
   input  logic                           i_tx_busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0]   LAST_RST    = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   state_t                 state_q,   state_d;
   logic [IDX_W-1:0]       last_q,    last_d;
   logic [NUM_REQ-1:0]     grant_q,   grant_d;
   logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
   logic                   tx_start_q, tx_start_d;

   logic [NUM_REQ-1:0]     elig_s;
   logic [NUM_REQ-1:0]     req_s;
   logic [IDX_W-1:0]       win_s;
   logic                   found_s;
   logic                   accept_s;

`ifdef UART_TX_ARB_LOCK_EN
   logic                   lock_held_q, lock_held_d;
   logic [IDX_W-1:0]       lock_idx_q,  lock_idx_d;

   // A held lock narrows eligibility to the lock owner, even if it is not valid.
   always_comb begin
      if (lock_held_q) begin
         elig_s = ONE_HOT_LSB << lock_idx_q;
      end else begin
         elig_s = {NUM_REQ{1'b1}};
      end
   end
`else
   logic                   unused_last_s;

   // Without locking every requester is always eligible; i_last has no use.
   always_comb begin
      elig_s        = {NUM_REQ{1'b1}};
      unused_last_s = ^i_last;
   end
`endif

   assign req_s = i_valid & elig_s;

   // Round-robin search starting one past the previous winner. Indices wrap
   // with an explicit subtract so non-power-of-2 NUM_REQ never aliases.
   always_comb begin
      int cand;
      found_s = 1'b0;
      win_s   = '0;
      cand    = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand    = int'(last_q) + i;
         cand    = (cand >= NUM_REQ) ? (cand - NUM_REQ) : cand;
         win_s   = (req_s[IDX_W'(cand)] && !found_s) ? IDX_W'(cand) : win_s;
         found_s = found_s | req_s[IDX_W'(cand)];
      end
   end

   assign accept_s = (state_q == ST_IDLE) && !i_tx_busy && found_s;

   // Ready strobe is combinational and forced low while reset is asserted.
   always_comb begin
      if (accept_s && !i_reset) begin
         o_ready = ONE_HOT_LSB << win_s;
      end else begin
         o_ready = '0;
      end
   end

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      grant_d    = grant_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_held_d = lock_held_q;
      lock_idx_d  = lock_idx_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               tx_data_d  = i_data[win_s*DATA_BITS +: DATA_BITS];
               grant_d    = ONE_HOT_LSB << win_s;
               last_d     = win_s;
               tx_start_d = 1'b1;
               state_d    = ST_START;
`ifdef UART_TX_ARB_LOCK_EN
               lock_held_d = ~i_last[win_s];
               lock_idx_d  = win_s;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            // Busy is not examined here: the UART only raises it a cycle later.
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (i_tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else begin
               state_d = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_DONE: begin
            if (!i_tx_busy) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end else begin
               state_d = ST_WAIT_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State and registered outputs with asynchronous active-high reset.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         last_q     <= LAST_RST;
         grant_q    <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
         lock_held_q <= 1'b0;
         lock_idx_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         grant_q    <= grant_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
`ifdef UART_TX_ARB_LOCK_EN
         lock_held_q <= lock_held_d;
         lock_idx_q  <= lock_idx_d;
`endif
      end
   end

   assign o_grant    = grant_q;
   assign o_tx_data  = tx_data_q;
   assign o_tx_start = tx_start_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: NUM_REQ=4, DATA_BITS=8, with a behavioural
// uart_tx (3 cycles per bit, 30-cycle frame) and a serial receiver.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int DB = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  valid = '0;
   logic [N-1:0]  last  = '0;
   logic [N*DB-1:0] data = '0;
   logic [N-1:0]  ready;
   logic [N-1:0]  grant;
   logic [DB-1:0] tx_data;
   logic          tx_start;
   logic          tx_busy;
   logic          force_busy = 1'b0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB)) dut (
      .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_data(data), .i_last(last),
      .o_ready(ready), .o_grant(grant), .o_tx_data(tx_data), .o_tx_start(tx_start),
      .i_tx_busy(tx_busy)
   );

   // ---------------- behavioural uart_tx (BAUD_DIV=3) ----------------
   logic       u_busy;
   logic [9:0] u_frame;
   int         u_tick, u_nbits;
   logic       u_tx;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         u_busy <= 1'b0; u_frame <= 10'h3FF; u_tick <= 0; u_nbits <= 0;
      end else if (!u_busy) begin
         if (tx_start) begin
            u_busy <= 1'b1; u_frame <= {1'b1, tx_data, 1'b0}; u_tick <= 0; u_nbits <= 0;
         end
      end else if (u_tick == 2) begin
         u_tick  <= 0;
         u_frame <= {1'b1, u_frame[9:1]};
         if (u_nbits == 9) u_busy <= 1'b0;
         else              u_nbits <= u_nbits + 1;
      end else begin
         u_tick <= u_tick + 1;
      end
   end
   assign u_tx    = u_busy ? u_frame[0] : 1'b1;
   assign tx_busy = u_busy | force_busy;

   // ---------------- reference model ----------------
   int         m_last, m_owner, m_since, m_lock;
   bit         m_seen;
   logic [7:0] m_data;
   int         order[$];
   logic [7:0] exp_bytes[$];
   int         acc_cyc[$];
   int         cyc;
   int         rx_cnt;
   logic [9:0] rx_sh;
   logic [7:0] rx_last;
   int         n_vec, n_miss;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_last = N - 1; m_owner = -1; m_since = 0; m_seen = 1'b0; m_lock = -1;
      m_data = 8'h00; rx_cnt = -1;
      order.delete(); exp_bytes.delete(); acc_cyc.delete();
   endfunction

   // The single compare process: every negedge, outputs vs. model, then advance.
   always @(negedge clk) begin
      int win;
      logic [N-1:0] exp_ready;
      int b;
      cyc++;
      if (rst) begin
         model_reset();
         chk("rst_ready", ready, 0);
         chk("rst_grant", grant, 0);
         chk("rst_start", tx_start, 0);
         chk("rst_data", tx_data, 0);
      end else begin
         win = -1;
         if (m_owner < 0 && !tx_busy) begin
            for (int i = 1; i <= N; i++) begin
               int k;
               k = (m_last + i) % N;
               if (win < 0 && valid[k] && (m_lock < 0 || m_lock == k)) win = k;
            end
         end
         exp_ready = (win >= 0) ? (N'(1) << win) : '0;
         chk("ready", ready, exp_ready);
         chk("grant", grant, (m_owner >= 0) ? (N'(1) << m_owner) : 0);
         chk("tx_start", tx_start, (m_owner >= 0 && m_since == 1) ? 1 : 0);
         chk("tx_data", tx_data, m_data);

         // serial receiver, sampling each 3-cycle bit in its middle cycle
         if (rx_cnt < 0) begin
            if (u_tx == 1'b0) rx_cnt = 0;
         end else begin
            rx_cnt++;
         end
         if (rx_cnt >= 0 && rx_cnt % 3 == 1) begin
            b = rx_cnt / 3;
            rx_sh[b] = u_tx;
            if (b == 9) begin
               chk("serial_start_bit", rx_sh[0], 0);
               chk("serial_stop_bit", rx_sh[9], 1);
               rx_last = rx_sh[8:1];
               if (exp_bytes.size() == 0) begin
                  n_vec++; n_miss++;
                  $display("FAIL serial_byte: got %0h expected no frame", rx_sh[8:1]);
               end else begin
                  chk("serial_byte", rx_sh[8:1], exp_bytes.pop_front());
               end
               rx_cnt = -1;
            end
         end

         if (m_owner < 0) begin
            if (win >= 0) begin
               m_owner = win; m_last = win; m_data = data[win*DB +: DB];
               m_since = 1; m_seen = 1'b0;
               order.push_back(win); exp_bytes.push_back(m_data); acc_cyc.push_back(cyc);
`ifdef UART_TX_ARB_LOCK_EN
               m_lock = last[win] ? -1 : win;
`endif
            end
         end else begin
            if (m_since >= 2 && !m_seen && tx_busy) m_seen = 1'b1;
            else if (m_seen && !tx_busy) m_owner = -1;
            m_since++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; valid = '0; last = '0; data = '0; force_busy = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic wait_grants(input int n, input int budget, input string name);
      int c = 0;
      while (order.size() < n && c < budget) begin tick(); c++; end
      n_vec++;
      if (order.size() < n) begin
         n_miss++;
         $display("FAIL %s: timeout with %0d grants, expected %0d", name, order.size(), n);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp2[6];
      int exp5[4];
      int c, idx;
      bit acc0;

      // ---- 1: single requester, 0xA5 ----
      do_reset();
      valid = 4'b0001; data[7:0] = 8'hA5;
      #1;
      chk("t1_ready", ready, 4'b0001);
      tick();
      chk("t1_start", tx_start, 1);
      chk("t1_data", tx_data, 8'hA5);
      chk("t1_ready_low", ready, 0);
      wait_grants(2, 100, "t1_second");
      if (acc_cyc.size() >= 2) chk("t1_period", acc_cyc[1] - acc_cyc[0], 33);
      chk("t1_serial", rx_last, 8'hA5);

      // ---- 2: all four valid, round robin from 0 ----
      do_reset();
      valid = 4'b1111; data = {8'h13, 8'h12, 8'h11, 8'h10};
      exp2 = '{0, 1, 2, 3, 0, 1};
      wait_grants(6, 300, "t2_grants");
      for (int i = 0; i < 6; i++) if (order.size() > i) chk("t2_order", order[i], exp2[i]);
      chk("t2_serial_last", rx_last, 8'h10);

      // ---- 3: only 2, then 1 and 3 ----
      do_reset();
      valid = 4'b0100; data = {8'h23, 8'h22, 8'h21, 8'h20};
      wait_grants(1, 20, "t3_first");
      valid = 4'b1010;
      wait_grants(3, 120, "t3_rest");
      if (order.size() >= 3) begin
         chk("t3_g0", order[0], 2);
         chk("t3_g1", order[1], 3);
         chk("t3_g2", order[2], 1);
      end

      // ---- 4: reset during WAIT_DONE ----
      do_reset();
      valid = 4'b0001; data[7:0] = 8'h3C;
      wait_grants(1, 20, "t4_first");
      repeat (8) tick();
      chk("t4_grant_held", grant, 4'b0001);
      valid = 4'b0011;
      rst = 1'b1;
      #1;
      chk("t4_rst_ready", ready, 0);
      chk("t4_rst_grant", grant, 0);
      chk("t4_rst_start", tx_start, 0);
      chk("t4_rst_data", tx_data, 0);
      tick();
      rst = 1'b0;
      wait_grants(1, 20, "t4_after");
      if (order.size() >= 1) chk("t4_g0", order[0], 0);

      // ---- 5: packet with i_last ----
      do_reset();
      valid = 4'b0011; data[15:8] = 8'h55; data[7:0] = 8'h01; last = '0;
      idx = 0; c = 0;
      while (order.size() < 4 && c < 400) begin
         @(negedge clk);
         acc0 = valid[0] && ready[0];
         @(posedge clk); #1;
         c++;
         if (acc0) begin
            idx++;
            if (idx < 3) begin
               data[7:0] = 8'(idx + 1);
               last[0]   = (idx == 2);
            end else begin
               valid[0] = 1'b0; last[0] = 1'b0;
            end
         end
      end
      chk("t5_done", (order.size() >= 4) ? 1 : 0, 1);
`ifdef UART_TX_ARB_LOCK_EN
      exp5 = '{0, 0, 0, 1};
`else
      exp5 = '{0, 1, 0, 1};
`endif
      for (int i = 0; i < 4; i++) if (order.size() > i) chk("t5_order", order[i], exp5[i]);

      // ---- 6: external busy in IDLE ----
      do_reset();
      force_busy = 1'b1; valid = 4'b0001; data[7:0] = 8'h66;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("t6_blocked", ready, 0);
         tick();
      end
      force_busy = 1'b0;
      #1;
      chk("t6_release", ready, 4'b0001);
      wait_grants(1, 20, "t6_grant");

      // ---- random traffic ----
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         valid      = N'($urandom_range(0, 15));
         data       = $urandom;
         last       = N'($urandom_range(0, 15));
         force_busy = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 999) == 0) begin
            rst = 1'b1; tick(); rst = 1'b0;
         end
         tick();
      end
      valid = '0; force_busy = 1'b0;
      repeat (80) tick();
      chk("final_idle_grant", grant, 0);
      chk("final_no_pending_frames", exp_bytes.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` instance among `NUM_REQ` byte sources. It accepts one byte at a time from a requester over a valid/ready handshake and issues a one-cycle start to the transmitter. It tracks the transmitter's busy flag so it never starts the transmitter while a frame is in progress. It sits between the application byte producers and the single UART pin driver.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters; legal range ≥ 2.
- `DATA_BITS`, 8: byte width; must equal the `DATA_BITS` of the attached `uart_tx`.

Ports. One clock; reset is asynchronous and active-high.
- `i_clk`  in  1  clock.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_valid`  in  NUM_REQ  per-requester byte valid.
- `i_data`  in  NUM_REQ*DATA_BITS  flattened bytes; requester k uses bits `[k*DATA_BITS +: DATA_BITS]`.
- `i_last`  in  NUM_REQ  marks the last byte of a packet; used only when `UART_TX_ARB_LOCK_EN` is defined.
- `o_ready`  out  NUM_REQ  one-hot accept strobe; a transfer occurs when `i_valid[k] && o_ready[k]`.
- `o_grant`  out  NUM_REQ  one-hot owner of the current frame; zero when idle.
- `o_tx_data`  out  DATA_BITS  registered byte; connects to `uart_tx.i_data`.
- `o_tx_start`  out  1  registered one-cycle start; connects to `uart_tx.i_start`.
- `i_tx_busy`  in  1  from `uart_tx.o_busy`.

## Operation

State machine, with states IDLE, START, WAIT_BUSY and WAIT_DONE:
- **IDLE:**
  - If `i_tx_busy == 0` and any eligible `i_valid` is high, pick winner w by round-robin search from `last+1` up to `last+NUM_REQ` (mod NUM_REQ).
  - Drive `o_ready[w]=1` combinationally in the same cycle.
  - Capture `i_data[w]` into `o_tx_data`, set `o_grant` to bit w, set `last` to w, and go to START.
- **START:** `o_tx_start=1` for exactly this cycle. Go to WAIT_BUSY.
- **WAIT_BUSY:** on `i_tx_busy==1`, go to WAIT_DONE. `o_tx_start` stays 0.
- **WAIT_DONE:** on `i_tx_busy==0`, go to IDLE and clear `o_grant`.

Rules:
- `o_ready` is zero in every state except IDLE.
- At most one bit of `o_ready` is high in any cycle.
- `o_tx_data` holds its value from acceptance until the next acceptance.
- `last` is a register of width `$clog2(NUM_REQ)`. Its reset value is `NUM_REQ-1`, so requester 0 has highest priority after reset.
- Search arithmetic is modulo NUM_REQ. There is no wrap glitch for non-power-of-2 NUM_REQ.
- Eligible: every requester, except when a lock is held (see Configuration).
- A requester that drops `i_valid` before it is granted is simply skipped. No state is kept for it.
- If `i_tx_busy` is already high in IDLE (for example, the UART was started externally), no grant is issued until it falls.

Reset values:
- `o_ready=0`, `o_grant=0`, `o_tx_data=0`, `o_tx_start=0`.
- State is IDLE, `last=NUM_REQ-1`, lock is cleared.

Reset mid-frame:
- All outputs return to their reset values immediately (asynchronously), and the arbiter returns to IDLE.
- The arbiter does not reset the UART. The bench resets both together.

## Timing

- Acceptance happens in cycle N. `o_tx_start` is high in cycle N+1. `uart_tx.o_busy` rises in N+2.
- `i_tx_busy` falls in cycle X, is seen in WAIT_DONE, and the arbiter is in IDLE at X+1. The earliest next acceptance is X+1.
- Throughput is one byte per `(frame cycles + 3)` cycles when requests are back-to-back.
- `o_ready` has a combinational path from `i_valid` and `i_tx_busy`. All other outputs are registered.

## Configuration

- **Macro `UART_TX_ARB_LOCK_EN` defined:**
  - Accepting a byte with `i_last[w]==0` sets the lock to w.
  - While the lock is held, only w is eligible, and other requesters wait even if w is not valid.
  - Accepting a byte from w with `i_last[w]==1` clears the lock.
  - Reset clears the lock.
- **Not defined:** `i_last` is ignored (left unconnected internally), and every byte is arbitrated independently.

## Test plan

Bench setup: `NUM_REQ=4`, `DATA_BITS=8`, `uart_tx` with `BAUD_DIV=3` (30-cycle frame).

1. Only `i_valid[0]`, with data 0xA5 → `o_ready[0]` is high for 1 cycle; the next cycle has `o_tx_start=1` and `o_tx_data=0xA5`. The serial line carries start bit, 0xA5 LSB-first, then stop bit. The next `o_ready` comes exactly 1 cycle after busy falls.
2. All four valid continuously, with data 0x10+k → grant order is 0,1,2,3,0,1. Each byte's serial frame matches its source.
3. After reset, only requester 2 valid → grant 2. Then requesters 1 and 3 are both valid → grant 3, then 1.
4. Assert `i_reset` during WAIT_DONE → all outputs are 0 in the same cycle. After release, with requesters 0 and 1 valid → grant 0 first.
5. Macro defined: requester 0 sends 0x01, 0x02, 0x03 with `i_last` set on 0x03, while requester 1 is valid throughout → order is 0,0,0,1. Macro undefined, same stimulus → order is 0,1,0,1.
6. `i_tx_busy` forced high in IDLE with requester 0 valid → no `o_ready` while it is high. `o_ready[0]` rises in the first cycle busy is low.
